ifu: RTL and testbench

Instruction fetch unit for the MIPS core. It holds the program counter, drives the word address into the asynchronous instruction memory, and selects the next PC: sequential, branch, jump, jump-register, exception vector or `eret`. It also holds the IF/ID pipeline register that passes the fetched instruction, its PC and its fetch-exception status to the decode stage.

---
 rtl/ifu_if.sv | 37 +++
 rtl/ifu.sv | 101 ++++++++++
 tb/tb_ifu.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/ifu_if.sv
// ifu_if: signal bundle between the instruction fetch unit and its
// surroundings (hazard unit, ID/EX control, CP0, instruction memory and
// the decode stage).
//   master : the fetch unit side (drives fetch address and IF/ID outputs)
//   slave  : the core/memory side (drives control, targets and im_data)
// Signals:
//   stall, npc_sel[1:0], is_jb, jr_target[31:0], exc_req, eret, epc[31:0]
//   im_addr[10:0], im_data[31:0]
//   pc_f, ir_d, pc_d, pc8_d [31:0], bd_d, exc_d, exc_code_d[4:0]
interface ifu_if;
  logic        stall;
  logic [1:0]  npc_sel;
  logic        is_jb;
  logic [31:0] jr_target;
  logic        exc_req;
  logic        eret;
  logic [31:0] epc;
  logic [10:0] im_addr;
  logic [31:0] im_data;
  logic [31:0] pc_f;
  logic [31:0] ir_d;
  logic [31:0] pc_d;
  logic [31:0] pc8_d;
  logic        bd_d;
  logic        exc_d;
  logic [4:0]  exc_code_d;

  modport master (
    input  stall, npc_sel, is_jb, jr_target, exc_req, eret, epc, im_data,
    output im_addr, pc_f, ir_d, pc_d, pc8_d, bd_d, exc_d, exc_code_d
  );

  modport slave (
    output stall, npc_sel, is_jb, jr_target, exc_req, eret, epc, im_data,
    input  im_addr, pc_f, ir_d, pc_d, pc8_d, bd_d, exc_d, exc_code_d
  );
endinterface

// File: rtl/ifu.sv
// ifu: instruction fetch unit for the MIPS core.
// Holds the fetch PC, drives the word address into the asynchronous
// instruction memory, selects the next PC (sequential, branch, jump,
// jump-register, exception vector, eret) and holds the IF/ID register.
// Ports:
//   clk   : clock, all state updates on the rising edge
//   reset : synchronous, active-high
//   bus   : ifu_if.master, control inputs, memory port and IF/ID outputs
module ifu #(
  parameter logic [31:0] PC_RESET   = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
  parameter logic [31:0] IM_LO      = 32'h0000_3000,
  parameter logic [31:0] IM_HI      = 32'h0000_4ffc
) (
  input  logic   clk,
  input  logic   reset,
  ifu_if.master  bus
);

  logic [31:0] pcf_q,  pcf_d;
  logic [31:0] irid_q, irid_d;
  logic [31:0] pcid_q, pcid_d;
  logic        bdid_q, bdid_d;
  logic        excid_q, excid_d;

  logic        fault;
  logic [31:0] pcid_plus4;
  logic [31:0] br_target;
  logic [31:0] j_target;
  logic [31:0] seq_pc;
  logic [31:0] sel_pc;

  // AdEL on the current fetch address
  assign fault = (pcf_q[1:0] != 2'b00) | (pcf_q < IM_LO) | (pcf_q > IM_HI);

  assign seq_pc     = pcf_q + 32'd4;
  assign pcid_plus4 = pcid_q + 32'd4;
  assign br_target  = pcid_plus4 + {{14{irid_q[15]}}, irid_q[15:0], 2'b00};
  assign j_target   = {pcid_plus4[31:28], irid_q[25:0], 2'b00};

  // Branch/jump targets come from the instruction in ID; the delay slot is
  // already being fetched, so the redirect lands on the following fetch.
  always_comb begin
    sel_pc = seq_pc;
    unique case (bus.npc_sel)
      2'd0: sel_pc = seq_pc;
      2'd1: sel_pc = br_target;
      2'd2: sel_pc = j_target;
      2'd3: sel_pc = bus.jr_target;
      default: sel_pc = seq_pc;
    endcase
  end

  always_comb begin
    pcf_d   = pcf_q;
    irid_d  = irid_q;
    pcid_d  = pcid_q;
    bdid_d  = bdid_q;
    excid_d = excid_q;
    if (bus.exc_req || bus.eret) begin
      // Flush: IF/ID becomes a bubble, no delay slot after eret
      pcf_d   = bus.exc_req ? EXC_VECTOR : bus.epc;
      irid_d  = '0;
      pcid_d  = pcf_q;
      bdid_d  = 1'b0;
      excid_d = 1'b0;
    end else if (!bus.stall) begin
      pcf_d   = sel_pc;
      irid_d  = fault ? '0 : bus.im_data;
      pcid_d  = pcf_q;
      bdid_d  = bus.is_jb;
      excid_d = fault;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pcf_q   <= PC_RESET;
      irid_q  <= '0;
      pcid_q  <= '0;
      bdid_q  <= 1'b0;
      excid_q <= 1'b0;
    end else begin
      pcf_q   <= pcf_d;
      irid_q  <= irid_d;
      pcid_q  <= pcid_d;
      bdid_q  <= bdid_d;
      excid_q <= excid_d;
    end
  end

  assign bus.im_addr    = pcf_q[12:2];
  assign bus.pc_f       = pcf_q;
  assign bus.ir_d       = irid_q;
  assign bus.pc_d       = pcid_q;
  assign bus.pc8_d      = pcid_q + 32'd8;
  assign bus.bd_d       = bdid_q;
  assign bus.exc_d      = excid_q;
  assign bus.exc_code_d = excid_q ? 5'd4 : 5'd0;

endmodule

// File: tb/tb_ifu.sv
// tb_ifu: directed bench for ifu with a word-array instruction memory.
// Default memory word at index i is 32'hA500_0000 | i; a few words are
// replaced by branch/jump instructions.
module tb_ifu;
  logic clk = 1'b0;
  logic reset;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [31:0] mem [0:2047];

  ifu_if bus ();

  ifu #(
    .PC_RESET   (32'h0000_3000),
    .EXC_VECTOR (32'h0000_4180),
    .IM_LO      (32'h0000_3000),
    .IM_HI      (32'h0000_4ffc)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.im_data = mem[bus.im_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Checks the whole observable state in one call.
  task automatic chk_all(input string tag, input logic [31:0] pcf, input logic [31:0] ir,
                         input logic [31:0] pcd, input logic bd, input logic exc);
    check({tag, ".pc_f"}, bus.pc_f, pcf);
    check({tag, ".im_addr"}, {21'd0, bus.im_addr}, {21'd0, pcf[12:2]});
    check({tag, ".ir_d"}, bus.ir_d, ir);
    check({tag, ".pc_d"}, bus.pc_d, pcd);
    check({tag, ".pc8_d"}, bus.pc8_d, pcd + 32'd8);
    check({tag, ".bd_d"}, {31'd0, bus.bd_d}, {31'd0, bd});
    check({tag, ".exc_d"}, {31'd0, bus.exc_d}, {31'd0, exc});
    check({tag, ".exc_code"}, {27'd0, bus.exc_code_d}, exc ? 32'd4 : 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 32'hA500_0000 | i;
    mem[11'h404] = 32'h1000_fffe;   // 3010: beq offset -2
    mem[11'h408] = 32'h0800_0c10;   // 3020: j 0xc10 -> 3040
    mem[11'h410] = 32'h03e0_0008;   // 3040: jr

    reset = 1'b1;
    bus.stall = 1'b0; bus.npc_sel = 2'd0; bus.is_jb = 1'b0;
    bus.jr_target = '0; bus.exc_req = 1'b0; bus.eret = 1'b0; bus.epc = '0;
    tick(); tick();
    reset = 1'b0;
    chk_all("reset", 32'h3000, 32'h0, 32'h0, 1'b0, 1'b0);

    // free-running fetch
    tick(); chk_all("seq1", 32'h3004, 32'hA500_0400, 32'h3000, 1'b0, 1'b0);
    tick(); chk_all("seq2", 32'h3008, 32'hA500_0401, 32'h3004, 1'b0, 1'b0);

    // stall for 3 cycles, npc_sel must be ignored
    bus.stall = 1'b1; bus.npc_sel = 2'd3; bus.jr_target = 32'h0000_3100;
    for (int i = 0; i < 3; i++) begin
      tick(); chk_all("stall", 32'h3008, 32'hA500_0401, 32'h3004, 1'b0, 1'b0);
    end
    bus.stall = 1'b0; bus.npc_sel = 2'd0;
    tick(); chk_all("rel1", 32'h300c, 32'hA500_0402, 32'h3008, 1'b0, 1'b0);
    tick(); chk_all("rel2", 32'h3010, 32'hA500_0403, 32'h300c, 1'b0, 1'b0);
    tick(); chk_all("beq_id", 32'h3014, 32'h1000_fffe, 32'h3010, 1'b0, 1'b0);

    // taken branch: target 3014 - 8 = 300c
    bus.npc_sel = 2'd1; bus.is_jb = 1'b1;
    tick(); chk_all("beq_taken", 32'h300c, 32'hA500_0405, 32'h3014, 1'b1, 1'b0);
    bus.npc_sel = 2'd0; bus.is_jb = 1'b0;
    tick(); chk_all("beq_after", 32'h3010, 32'hA500_0403, 32'h300c, 1'b0, 1'b0);
    tick(); chk_all("beq_id2", 32'h3014, 32'h1000_fffe, 32'h3010, 1'b0, 1'b0);
    // not-taken branch still marks the delay slot
    bus.is_jb = 1'b1;
    tick(); chk_all("beq_nt", 32'h3018, 32'hA500_0405, 32'h3014, 1'b1, 1'b0);
    bus.is_jb = 1'b0;
    tick(); tick(); tick();
    chk_all("j_id", 32'h3024, 32'h0800_0c10, 32'h3020, 1'b0, 1'b0);

    // jump
    bus.npc_sel = 2'd2; bus.is_jb = 1'b1;
    tick(); chk_all("j_taken", 32'h3040, 32'hA500_0409, 32'h3024, 1'b1, 1'b0);
    bus.npc_sel = 2'd0; bus.is_jb = 1'b0;
    tick(); chk_all("jr_id", 32'h3044, 32'h03e0_0008, 32'h3040, 1'b0, 1'b0);
    bus.npc_sel = 2'd3; bus.is_jb = 1'b1; bus.jr_target = 32'h0000_3100;
    tick(); chk_all("jr_taken", 32'h3100, 32'hA500_0411, 32'h3044, 1'b1, 1'b0);
    bus.npc_sel = 2'd0; bus.is_jb = 1'b0;
    tick(); chk_all("jr_after", 32'h3104, 32'hA500_0440, 32'h3100, 1'b0, 1'b0);

    // exception overrides stall
    bus.stall = 1'b1; bus.exc_req = 1'b1;
    tick(); chk_all("exc", 32'h4180, 32'h0, 32'h3104, 1'b0, 1'b0);
    bus.stall = 1'b0; bus.exc_req = 1'b0;
    tick(); chk_all("vec", 32'h4184, 32'hA500_0060, 32'h4180, 1'b0, 1'b0);
    bus.eret = 1'b1; bus.epc = 32'h0000_3024;
    tick(); chk_all("eret", 32'h3024, 32'h0, 32'h4184, 1'b0, 1'b0);
    bus.eret = 1'b0;
    tick(); chk_all("eret_ret", 32'h3028, 32'hA500_0409, 32'h3024, 1'b0, 1'b0);

    // misaligned jr target faults on fetch
    bus.npc_sel = 2'd3; bus.jr_target = 32'h0000_3002;
    tick(); chk_all("mis_pc", 32'h3002, 32'hA500_040a, 32'h3028, 1'b0, 1'b0);
    bus.npc_sel = 2'd0;
    tick(); chk_all("mis_fault", 32'h3006, 32'h0, 32'h3002, 1'b0, 1'b1);
    tick(); chk_all("mis_fault2", 32'h300a, 32'h0, 32'h3006, 1'b0, 1'b1);
    // exc_req wins over eret
    bus.exc_req = 1'b1; bus.eret = 1'b1; bus.epc = 32'h0000_3024;
    tick(); chk_all("exc_eret", 32'h4180, 32'h0, 32'h300a, 1'b0, 1'b0);
    bus.exc_req = 1'b0; bus.eret = 1'b0;

    // above IM_HI
    bus.npc_sel = 2'd3; bus.jr_target = 32'h0000_5000;
    tick(); chk_all("hi_pc", 32'h5000, 32'hA500_0060, 32'h4180, 1'b0, 1'b0);
    bus.jr_target = 32'h0000_4ffc;
    tick(); chk_all("hi_fault", 32'h4ffc, 32'h0, 32'h5000, 1'b0, 1'b1);
    // IM_HI itself is legal; below IM_LO faults
    bus.jr_target = 32'h0000_2ffc;
    tick(); chk_all("hi_edge", 32'h2ffc, 32'hA500_03ff, 32'h4ffc, 1'b0, 1'b0);
    bus.npc_sel = 2'd0;
    tick(); chk_all("lo_fault", 32'h3000, 32'h0, 32'h2ffc, 1'b0, 1'b1);

    // reset during stall and redirect
    bus.stall = 1'b1; bus.npc_sel = 2'd3; reset = 1'b1;
    tick(); chk_all("reset2", 32'h3000, 32'h0, 32'h0, 1'b0, 1'b0);
    reset = 1'b0; bus.stall = 1'b0; bus.npc_sel = 2'd0;
    tick(); chk_all("post_reset", 32'h3004, 32'hA500_0400, 32'h3000, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
